// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
package imem_pkg;

  localparam int DATA_WIDTH     = 20;
  localparam int ADDRESS_WIDTH  = 8;
  localparam int MEM_SIZE       = 256;
  localparam int BYTES_PER_WORD = (DATA_WIDTH + 7) / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  function automatic int bytes_per_word(input int dw);
    return (dw + 7) / 8;
  endfunction

  function automatic int byte_idx_width(input int dw);
    return (bytes_per_word(dw) > 1) ? $clog2(bytes_per_word(dw)) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Little-endian byte-to-word assembler; exposes the word including the byte
// being accepted this cycle so the caller can register it on the same edge.
module byte_word_packer
  import imem_pkg::*;
#(
  parameter  int DATA_WIDTH = imem_pkg::DATA_WIDTH,
  localparam int IDX_W      = byte_idx_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  byte_strobe,
  input  logic [IDX_W-1:0]      byte_idx,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  overflow
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int EXT_W = 8 * BPW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  logic [DATA_WIDTH-1:0] word_q;
  logic [EXT_W-1:0]      merged;

  // Upper bits of word_q are always zero, so anything above DATA_WIDTH-1 in
  // merged can only come from the final byte.
  always_comb begin
    merged = '0;
    merged[DATA_WIDTH-1:0] = word_q;
    if (byte_strobe) begin
      merged[{byte_idx, 3'b000} +: 8] = byte_data;
    end
  end

  assign word     = merged[DATA_WIDTH-1:0];
  assign overflow = byte_strobe && (byte_idx == LAST_IDX) && (|(merged >> DATA_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (clear) begin
      word_q <= '0;
    end else if (byte_strobe) begin
      word_q <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory writer: packs a byte stream into words and writes them
// at consecutive (wrapping) addresses, holding the core off while loading.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a legal start; illegal count sets error
//   ST_RECV  | accepting bytes of the current word (in_ready=1)
//   ST_WRITE | registered write of the packed word is on the port
//   ST_DONE  | one-cycle done pulse, then back to idle
module imem_loader
  import imem_pkg::*;
#(
  parameter  int DATA_WIDTH    = imem_pkg::DATA_WIDTH,
  parameter  int ADDRESS_WIDTH = imem_pkg::ADDRESS_WIDTH,
  parameter  int MEM_SIZE      = imem_pkg::MEM_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   num_words,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     busy,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = byte_idx_width(DATA_WIDTH);
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(BPW - 1);
  localparam logic [ADDRESS_WIDTH:0] MEM_SIZE_C = (ADDRESS_WIDTH + 1)'(MEM_SIZE);

  loader_state_t state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [ADDRESS_WIDTH:0]   num_q;
  logic [ADDRESS_WIDTH:0]   word_cnt_q;
  logic [IDX_W-1:0]         byte_idx_q;
  logic                     error_q;
  logic                     mem_we_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;

  logic                     count_legal;
  logic                     start_take;
  logic                     byte_fire;
  logic                     last_byte;
  logic                     last_word;
  logic                     pk_clear;
  logic                     pk_ovf;
  logic [DATA_WIDTH-1:0]    pk_word;
  logic [ADDRESS_WIDTH:0]   addr_sum;
  logic [ADDRESS_WIDTH-1:0] addr_next;

  assign count_legal = (num_words != '0) && (num_words <= MEM_SIZE_C);
  assign start_take  = (state_q == ST_IDLE) && start && !abort;
  assign byte_fire   = in_valid && in_ready;
  assign last_byte   = byte_fire && (byte_idx_q == LAST_IDX);
  assign last_word   = ((word_cnt_q + 1'b1) == num_q);
  assign pk_clear    = start_take || (state_q == ST_WRITE);

  // base < MEM_SIZE and word_cnt < MEM_SIZE, so one conditional subtract wraps.
  always_comb begin
    addr_sum = {1'b0, base_q} + word_cnt_q;
    if (addr_sum >= MEM_SIZE_C) begin
      addr_sum = addr_sum - MEM_SIZE_C;
    end
    addr_next = addr_sum[ADDRESS_WIDTH-1:0];
  end

  byte_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (pk_clear),
    .byte_strobe (byte_fire),
    .byte_idx    (byte_idx_q),
    .byte_data   (in_data),
    .word        (pk_word),
    .overflow    (pk_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_take && count_legal) begin
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_byte) begin
          state_d = pk_ovf ? ST_IDLE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = last_word ? ST_DONE : ST_RECV;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // An abort on the final-byte edge cancels the write before it is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      num_q       <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      error_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (start_take) begin
        if (count_legal) begin
          base_q     <= base_addr;
          num_q      <= num_words;
          word_cnt_q <= '0;
          byte_idx_q <= '0;
          error_q    <= 1'b0;
        end else begin
          error_q <= 1'b1;
        end
      end
      if ((state_q == ST_RECV) && !abort && byte_fire) begin
        if (last_byte) begin
          byte_idx_q <= '0;
          if (pk_ovf) begin
            error_q <= 1'b1;
          end else begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_next;
            mem_wdata_q <= pk_word;
          end
        end else begin
          byte_idx_q <= byte_idx_q + 1'b1;
        end
      end
      if ((state_q == ST_WRITE) && !abort) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == ST_RECV);
  assign busy      = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign cpu_hold  = busy;
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: randomized byte loads against a word-level model.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int DW  = DATA_WIDTH;
  localparam int AW  = ADDRESS_WIDTH;
  localparam int BPW = BYTES_PER_WORD;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready, mem_we, busy, cpu_hold, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned exp_addr[$];
  longint      exp_data[$];
  int          exp_done = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops expected writes / done pulses as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cpu_hold_eq_busy", cpu_hold, busy);
      if (mem_we) begin
        check("ready_low_in_write", in_ready, 0);
        check("write_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) begin
          check("wr_addr", mem_addr, exp_addr.pop_front());
          check("wr_data", mem_wdata, exp_data.pop_front());
        end
      end
      if (done) begin
        check("done_expected", exp_done > 0, 1);
        check("done_not_busy", busy, 0);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  // Word-level reference: which words reach memory, and whether error is raised.
  task automatic model_load(input int base, input int n, input byte_q_t b,
                            input int abort_after, output int err);
    longint word;
    err = 0;
    for (int w = 0; w < n; w++) begin
      if (abort_after >= 0 && BPW * (w + 1) > abort_after) return;
      word = 0;
      for (int k = 0; k < BPW; k++) word = word | (longint'(b[BPW*w+k]) << (8 * k));
      if ((word >> DW) != 0) begin
        err = 1;
        return;
      end
      exp_addr.push_back((base + w) % MEM_SIZE);
      exp_data.push_back(word);
    end
    exp_done++;
  endtask

  task automatic run_load(input int base, input int n, input byte_q_t bytes,
                          input int abort_after, input int gap_pct);
    byte_q_t bq;
    int consumed;
    int exp_err;
    bq = bytes;
    consumed = 0;
    model_load(base, n, bytes, abort_after, exp_err);
    @(negedge clk);
    base_addr = AW'(base);
    num_words = (AW+1)'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (!busy) break;
      if (abort_after >= 0 && consumed == abort_after) begin
        start = 1'b0;
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        continue;
      end
      // start pulses while busy must be ignored
      start = ($urandom_range(0, 9) == 0);
      base_addr = AW'($urandom);
      num_words = (AW+1)'($urandom);
      if (bq.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        in_valid = 1'b1;
        in_data = bq[0];
      end else begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
      end
      if (in_valid && in_ready) begin
        void'(bq.pop_front());
        consumed++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("load_terminated", busy, 0);
    repeat (3) @(negedge clk);
    check("error_flag", error, exp_err);
    check("writes_drained", exp_addr.size(), 0);
    check("done_drained", exp_done, 0);
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
  endtask

  function automatic byte_q_t rand_bytes(input int n, input int bad_pct);
    byte_q_t q;
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < BPW - 1; k++) q.push_back(8'($urandom));
      if ($urandom_range(0, 99) < bad_pct) q.push_back(8'($urandom_range(16, 255)));
      else q.push_back(8'($urandom_range(0, 15)));
    end
    return q;
  endfunction

  task automatic illegal_start(input int n);
    @(negedge clk);
    num_words = (AW+1)'(n);
    base_addr = AW'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      check("illegal_busy", busy, 0);
      check("illegal_ready", in_ready, 0);
      @(negedge clk);
    end
    check("illegal_error", error, 1);
  endtask

  function automatic longint all_outputs();
    return longint'({in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t b;
    int n, ab, gap;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    b = '{8'h34, 8'h12, 8'h05, 8'hCD, 8'hAB, 8'h0F};
    run_load(32'h10, 2, b, -1, 0);
    run_load(32'h10, 2, b, -1, 60);

    b = '{8'h01, 8'h02, 8'h15};
    run_load(32'h20, 1, b, -1, 0);
    run_load(32'hFF, 2, rand_bytes(2, 0), -1, 20);

    illegal_start(0);
    illegal_start(MEM_SIZE + 1);
    // abort together with start: start ignored, so error stays set
    @(negedge clk);
    num_words = 1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 0);
    check("abort_start_error", error, 1);

    run_load(32'h40, 2, rand_bytes(2, 0), 4, 0);

    // reset mid-load after one byte
    @(negedge clk);
    base_addr = 8'h50;
    num_words = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midload_reset_outputs", all_outputs(), 0);
    @(negedge clk);
    check("midload_reset_hold", all_outputs(), 0);
    rst_n = 1'b1;
    run_load(32'h50, 1, rand_bytes(1, 0), -1, 0);

    run_load($urandom_range(0, MEM_SIZE - 1), MEM_SIZE, rand_bytes(MEM_SIZE, 0), -1, 0);

    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(1, 6);
      gap = $urandom_range(0, 50);
      ab = -1;
      if ($urandom_range(0, 4) == 0) ab = BPW * $urandom_range(0, n - 1) + $urandom_range(1, BPW - 1);
      run_load($urandom_range(0, MEM_SIZE - 1), n, rand_bytes(n, 15), ab, gap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory.
- Receives a byte stream over a valid/ready handshake and packs it into DATA_WIDTH-bit instruction words, little-endian.
- Writes each word through a single-cycle write port at consecutive addresses from a base address.
- Holds the core off while loading and pulses done when the requested word count has been written.

Parameters:
- DATA_WIDTH, 20, instruction word width.
- ADDRESS_WIDTH, 8, memory address width.
- MEM_SIZE, 256, number of memory entries; addresses wrap modulo MEM_SIZE.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  single-cycle request to begin a load.
- base_addr  input  ADDRESS_WIDTH  first write address, sampled on accepted start.
- num_words  input  ADDRESS_WIDTH+1  words to load, sampled on accepted start; legal range 1..MEM_SIZE.
- abort  input  1  cancel the current load.
- in_valid  input  1  byte available.
- in_data  input  8  byte payload.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  memory write enable, one cycle per word.
- mem_addr  output  ADDRESS_WIDTH  write address.
- mem_wdata  output  DATA_WIDTH  write data.
- busy  output  1  load in progress.
- cpu_hold  output  1  stall request to the core; equals busy.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky fault flag; cleared by the next accepted start.

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- While rst_n is low, every output is 0, all state and counters are cleared and the FSM is in IDLE.
- A byte transfer occurs on the rising clk edge where in_valid and in_ready are both 1.
- BYTES_PER_WORD = ceil(DATA_WIDTH/8); 3 for the defaults.
- FSM states are IDLE, RECV, WRITE and DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start with num_words==0 or num_words>MEM_SIZE: error=1, stay in IDLE, no write.
  - start with a legal count: latch base_addr and num_words, clear error, word_cnt=0, byte_idx=0, go to RECV.
- RECV:
  - in_ready=1, busy=1.
  - Byte k goes to word bits [8k+7:8k], truncated at DATA_WIDTH.
  - Final byte: any bit above DATA_WIDTH-1 set (bits 7:4 for the defaults) means error=1, go to IDLE, no write for that word.
  - Otherwise, after the final byte, go to WRITE.
  - Partial bytes are never written.
- WRITE:
  - in_ready=0, busy=1.
  - mem_we=1 for exactly one cycle.
  - mem_addr = (base_addr + word_cnt) mod MEM_SIZE; mem_wdata = the packed word. All three are registered.
  - Then word_cnt increments.
  - If word_cnt+1==num_words, go to DONE; else byte_idx=0 and go to RECV.
- DONE:
  - done=1 for one cycle, busy=0, then go to IDLE.
- Latency:
  - mem_we is asserted in the cycle after the final byte of a word is accepted.
  - done is asserted in the cycle after the last write.
  - Peak throughput is BYTES_PER_WORD+1 cycles per word.
- Simultaneous and mid-operation events:
  - start while busy: ignored.
  - abort in RECV or WRITE: go to IDLE next cycle, suppress any pending mem_we, error unchanged, no done.
  - abort in IDLE: no effect.
  - abort together with start in IDLE: abort wins and start is ignored.
  - rst_n asserted mid-load: memory contents already written are retained; a following start restarts from byte 0.
- Data presented while in_ready=0 is not consumed; the producer must hold it.

Decomposition:
- Shared package imem_pkg holds:
  - DATA_WIDTH, ADDRESS_WIDTH, MEM_SIZE, BYTES_PER_WORD.
  - The FSM state enum loader_state_t.
- One sub-module, byte_word_packer:
  - Inputs: byte_idx, byte strobe, clear.
  - Outputs: the packed word and an overflow-bit flag.
- The FSM, address and word counter live in imem_loader.

Test Plan:
1. Normal load: base_addr=0x10, num_words=2, bytes 34 12 05 CD AB 0F -> mem_we at 0x10 with 0x51234, then at 0x11 with 0xFABCD; done pulses once; busy and cpu_hold high from the cycle after start until the DONE cycle.
2. Backpressure and gaps: same stream with in_valid low for 3 random cycles between bytes -> identical writes; in_ready=0 during every WRITE cycle; no byte is lost or duplicated.
3. Format error: word bytes 01 02 15 -> error=1, no mem_we, returns to IDLE; a following legal start clears error.
4. Address wrap: base_addr=0xFF, num_words=2 -> writes at 0xFF then 0x00.
5. Illegal count: start with num_words=0, then with 257 -> error=1, busy stays 0, no in_ready.
6. Abort and reset mid-load: abort after 4 bytes -> one write only, no done, error=0. rst_n low after 1 byte -> all outputs 0 during reset; a following load of 1 word writes only the new data.
